// File: rtl/cla_pkg.sv
// cla_pkg: shared lookahead width, per-group propagate/generate pair and group P/G helper
package cla_pkg;

    localparam int LCU_W = 4;

    typedef struct packed {
        logic [LCU_W-1:0] p;
        logic [LCU_W-1:0] g;
    } pg4_t;

    // Returns {group_propagate, group_generate} for one 4-bit slice.
    function automatic logic [1:0] group_pg(input pg4_t x);
        return {&x.p,
                x.g[3] | (x.p[3] & x.g[2]) | (x.p[3] & x.p[2] & x.g[1]) |
                (x.p[3] & x.p[2] & x.p[1] & x.g[0])};
    endfunction

endpackage

// File: rtl/cla_lcu4.sv
// cla_lcu4: 4-bit lookahead carry unit producing per-bit carries and group P/G
module cla_lcu4
    import cla_pkg::*;
(
    input  pg4_t             pg,
    input  logic             c_in,
    output logic [LCU_W-1:0] c,
    output logic             gp,
    output logic             gg
);

    // Flat two-level carries into each bit; the carry out of the group is formed
    // by the caller from gp/gg so groups chain at the group level.
    always_comb begin
        c[0] = c_in;
        c[1] = pg.g[0] | (pg.p[0] & c_in);
        c[2] = pg.g[1] | (pg.p[1] & pg.g[0]) | (pg.p[1] & pg.p[0] & c_in);
        c[3] = pg.g[2] | (pg.p[2] & pg.g[1]) | (pg.p[2] & pg.p[1] & pg.g[0]) |
               (pg.p[2] & pg.p[1] & pg.p[0] & c_in);
        {gp, gg} = group_pg(pg);
    end

endmodule

// File: rtl/cla_addsub_pipe.sv
// cla_addsub_pipe: two-stage pipelined lookahead adder/subtractor with valid/ready on both sides
module cla_addsub_pipe
    import cla_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             c_out,
    output logic             ovf,
    output logic             zero
);

    localparam int HALF = WIDTH / 2;
    localparam int NG   = HALF / LCU_W;

    logic             s1_valid_q, s1_valid_d;
    logic [HALF-1:0]  s1_sum_lo_q, s1_sum_lo_d;
    logic             s1_carry_q, s1_carry_d;
    logic [HALF-1:0]  s1_a_hi_q, s1_a_hi_d;
    logic [HALF-1:0]  s1_b_hi_q, s1_b_hi_d;
    logic             s1_a_msb_q, s1_a_msb_d;
    logic             s1_b_msb_q, s1_b_msb_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             c_out_q, c_out_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;

    logic             out_adv, s1_adv, ld1, ld2;
    logic [WIDTH-1:0] b_eff;
    logic [HALF-1:0]  p_lo, g_lo, c_lo, p_hi, g_hi, c_hi, sum_hi;
    logic [NG:0]      gc_lo, gc_hi;
    logic [NG-1:0]    gp_lo, gg_lo, gp_hi, gg_hi;

    assign b_eff    = sub ? ~b : b;
    assign p_lo     = a[HALF-1:0] ^ b_eff[HALF-1:0];
    assign g_lo     = a[HALF-1:0] & b_eff[HALF-1:0];
    assign gc_lo[0] = sub;
    assign p_hi     = s1_a_hi_q ^ s1_b_hi_q;
    assign g_hi     = s1_a_hi_q & s1_b_hi_q;
    assign gc_hi[0] = s1_carry_q;
    assign sum_hi   = p_hi ^ c_hi;

    for (genvar i = 0; i < NG; i++) begin : g_lcu
        cla_lcu4 u_lo (
            .pg   ({p_lo[i*LCU_W +: LCU_W], g_lo[i*LCU_W +: LCU_W]}),
            .c_in (gc_lo[i]),
            .c    (c_lo[i*LCU_W +: LCU_W]),
            .gp   (gp_lo[i]),
            .gg   (gg_lo[i])
        );
        cla_lcu4 u_hi (
            .pg   ({p_hi[i*LCU_W +: LCU_W], g_hi[i*LCU_W +: LCU_W]}),
            .c_in (gc_hi[i]),
            .c    (c_hi[i*LCU_W +: LCU_W]),
            .gp   (gp_hi[i]),
            .gg   (gg_hi[i])
        );
        assign gc_lo[i+1] = gg_lo[i] | (gp_lo[i] & gc_lo[i]);
        assign gc_hi[i+1] = gg_hi[i] | (gp_hi[i] & gc_hi[i]);
    end

    // Handshake and next-state: each stage loads only when it advances, otherwise holds.
    always_comb begin
        out_adv     = !out_valid_q || out_ready;
        s1_adv      = !s1_valid_q || out_adv;
        in_ready    = !rst && s1_adv;
        ld1         = s1_adv && in_valid;
        ld2         = out_adv && s1_valid_q;
        s1_valid_d  = s1_adv ? in_valid : s1_valid_q;
        s1_sum_lo_d = ld1 ? p_lo ^ c_lo : s1_sum_lo_q;
        s1_carry_d  = ld1 ? gc_lo[NG] : s1_carry_q;
        s1_a_hi_d   = ld1 ? a[WIDTH-1:HALF] : s1_a_hi_q;
        s1_b_hi_d   = ld1 ? b_eff[WIDTH-1:HALF] : s1_b_hi_q;
        s1_a_msb_d  = ld1 ? a[WIDTH-1] : s1_a_msb_q;
        s1_b_msb_d  = ld1 ? b_eff[WIDTH-1] : s1_b_msb_q;
        out_valid_d = out_adv ? s1_valid_q : out_valid_q;
        result_d    = ld2 ? {sum_hi, s1_sum_lo_q} : result_q;
        c_out_d     = ld2 ? gc_hi[NG] : c_out_q;
        ovf_d       = ld2 ? (s1_a_msb_q == s1_b_msb_q) && (sum_hi[HALF-1] != s1_a_msb_q) : ovf_q;
        zero_d      = ld2 ? ~|{sum_hi, s1_sum_lo_q} : zero_q;
    end

    // Pipeline registers; reset discards every in-flight beat and clears the outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_sum_lo_q <= '0;
            s1_carry_q  <= 1'b0;
            s1_a_hi_q   <= '0;
            s1_b_hi_q   <= '0;
            s1_a_msb_q  <= 1'b0;
            s1_b_msb_q  <= 1'b0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            c_out_q     <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_sum_lo_q <= s1_sum_lo_d;
            s1_carry_q  <= s1_carry_d;
            s1_a_hi_q   <= s1_a_hi_d;
            s1_b_hi_q   <= s1_b_hi_d;
            s1_a_msb_q  <= s1_a_msb_d;
            s1_b_msb_q  <= s1_b_msb_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            c_out_q     <= c_out_d;
            ovf_q       <= ovf_d;
            zero_q      <= zero_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign c_out     = c_out_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_cla_addsub_pipe.sv
// tb_cla_addsub_pipe: scoreboard bench with an arithmetic reference model for cla_addsub_pipe
module tb_cla_addsub_pipe;

    localparam int W = 16;

    typedef struct {
        logic [W-1:0] res;
        logic         c;
        logic         v;
        logic         z;
        int           acc;
        logic         strict;
    } exp_t;

    logic         clk = 0, rst = 1, in_valid = 0, sub = 0, out_ready = 0;
    logic         in_ready, out_valid, c_out, ovf, zero;
    logic [W-1:0] a = '0, b = '0, result;

    exp_t sb[$];
    int   checks = 0, errors = 0, cyc = 0;
    logic strict = 1;

    cla_addsub_pipe #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .c_out     (c_out),
        .ovf       (ovf),
        .zero      (zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain unsigned/signed integer arithmetic on the operands.
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        exp_t e;
        int sx, sy, r;
        sx = int'($signed(x));
        sy = int'($signed(y));
        r = s ? sx - sy : sx + sy;
        e.res = s ? x - y : x + y;
        e.c = s ? (x >= y) : ((int'(x) + int'(y)) > 65535);
        e.v = (r > 32767) || (r < -32768);
        e.z = (e.res == '0);
        e.acc = cyc;
        e.strict = strict;
        return e;
    endfunction

    function automatic logic [W-1:0] rnd();
        logic [W-1:0] t [4] = '{16'h0000, 16'hFFFF, 16'h8000, 16'h7FFF};
        return ($urandom_range(0, 3) == 0) ? t[$urandom_range(0, 3)] : W'($urandom);
    endfunction

    task automatic cycle(input logic v, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic s, input logic ordy, output logic acc);
        @(negedge clk);
        in_valid = v;
        a = x;
        b = y;
        sub = s;
        out_ready = ordy;
        #1;
        acc = v && in_ready;
        if (acc) sb.push_back(model(x, y, s));
    endtask

    task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        logic acc = 0;
        for (int n = 0; n < 100 && !acc; n++) cycle(1'b1, x, y, s, 1'b1, acc);
        chk("send_accept", {31'd0, acc}, 1);
    endtask

    task automatic idle(input int n, input logic ordy);
        logic acc;
        repeat (n) cycle(1'b0, '0, '0, 1'b0, ordy, acc);
    endtask

    // Monitor: pops on every output transfer and checks output stability under backpressure.
    logic         held = 0;
    logic [W+2:0] held_val = '0;
    always @(negedge clk) begin
        exp_t e;
        #2;
        if (out_valid) begin
            if (held) chk("hold_stable", {13'd0, result, c_out, ovf, zero}, {13'd0, held_val});
            if (out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got %0h, expected no output", result);
                end else begin
                    e = sb.pop_front();
                    chk("result", {16'd0, result}, {16'd0, e.res});
                    chk("c_out", {31'd0, c_out}, {31'd0, e.c});
                    chk("ovf", {31'd0, ovf}, {31'd0, e.v});
                    chk("zero", {31'd0, zero}, {31'd0, e.z});
                    if (e.strict) chk("latency", cyc - e.acc, 2);
                end
            end
        end
        held = out_valid && !out_ready;
        held_val = {result, c_out, ovf, zero};
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic acc;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 0);
        chk("rst_out_valid", {31'd0, out_valid}, 0);
        chk("rst_outputs", {13'd0, result, c_out, ovf, zero}, 0);
        @(negedge clk);
        rst = 0;
        out_ready = 1;
        #1;
        chk("post_rst_in_ready", {31'd0, in_ready}, 1);
        send(16'h7FFF, 16'h0001, 1'b0);
        send(16'h0005, 16'h0007, 1'b1);
        send(16'hFFFF, 16'h0001, 1'b0);
        send(16'h8000, 16'h0001, 1'b1);
        idle(4, 1'b1);
        strict = 0;
        cycle(1'b1, 16'h1111, 16'h2222, 1'b0, 1'b0, acc);
        chk("bp_accept1", {31'd0, acc}, 1);
        cycle(1'b1, 16'hA000, 16'h0FFF, 1'b1, 1'b0, acc);
        chk("bp_accept2", {31'd0, acc}, 1);
        cycle(1'b1, 16'h0F0F, 16'hF0F0, 1'b0, 1'b0, acc);
        chk("bp_in_ready_low", {31'd0, in_ready}, 0);
        cycle(1'b1, 16'h0F0F, 16'hF0F0, 1'b0, 1'b0, acc);
        chk("bp_in_ready_low2", {31'd0, in_ready}, 0);
        send(16'h0F0F, 16'hF0F0, 1'b0);
        idle(4, 1'b1);
        chk("bp_drained", sb.size(), 0);
        strict = 1;
        send(16'h1234, 16'h1111, 1'b0);
        @(negedge clk);
        rst = 1;
        in_valid = 0;
        sb.delete();
        @(negedge clk);
        #1;
        chk("midrst_out_valid", {31'd0, out_valid}, 0);
        chk("midrst_outputs", {13'd0, result, c_out, ovf, zero}, 0);
        rst = 0;
        @(negedge clk);
        #1;
        chk("after_rst_out_valid", {31'd0, out_valid}, 0);
        send(16'h0001, 16'h0002, 1'b0);
        idle(4, 1'b1);
        strict = 0;
        for (int n = 0; n < 400; n++)
            cycle($urandom_range(0, 3) != 0, rnd(), rnd(), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 9) < 7, acc);
        for (int n = 0; n < 50 && sb.size() != 0; n++) idle(1, 1'b1);
        idle(3, 1'b1);
        chk("final_drain", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cla_addsub_pipe.md
Name: cla_addsub_pipe

Overview:
- Two-stage pipelined carry-lookahead adder/subtractor for the datapath.
- Add is a + b; subtract is the inverse direction, a + ~b + 1.
- Lower half resolves in stage 1 and upper half in stage 2, both built from 4-bit lookahead carry units chained through group P/G.
- Sits between the operand register file and the ALU result mux, with valid/ready handshakes on both sides.

Parameters:
- WIDTH, 16, operand/result width; must be a multiple of 8.
- HALF, WIDTH/2, stage-1 slice width (derived, not overridable).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block can accept a beat this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- sub  input  1  0 = add, 1 = subtract.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- result  output  WIDTH  sum/difference, modulo 2^WIDTH.
- c_out  output  1  carry out of MSB; for subtract, 1 = no borrow (a >= b unsigned).
- ovf  output  1  signed overflow.
- zero  output  1  result == 0.

Behaviour:
- One clock domain; reset is synchronous, active-high, sampled on the rising edge of clk.
- Reset state: both stage valid bits 0, out_valid 0, result/c_out/ovf/zero all 0.
- In reset cycle in_ready=0; it is 1 from the first cycle after reset deasserts if the pipe can advance.
- Operand prep (combinational, stage 1): b_eff = sub ? ~b : b; c0 = sub.
- Stage 1 register captures:
  - lower HALF sum bits;
  - carry into bit HALF (from 4-bit LCU group P/G plus c0);
  - upper HALF bits of a and b_eff;
  - a[MSB] and b_eff[MSB].
- Stage 2: upper sum via a second LCU chain seeded by the registered carry. Output register captures:
  - result;
  - c_out = final carry;
  - ovf = (a_msb == b_eff_msb) && (result[MSB] != a_msb);
  - zero = ~|result.
- Latency: 2 cycles from accepted beat (in_valid && in_ready) to out_valid, with no stalls.
- Throughput: one beat per cycle when out_ready is held high.
- Handshake:
  - stage advances when (stage empty) or (next stage advances); output stage advances when !out_valid or out_ready.
  - in_ready = stage-1 advance condition; purely combinational from out_ready and the valid bits, never from in_valid.
  - result/flags/out_valid hold stable while out_valid && !out_ready.
  - with out_ready low, the pipe fills: two beats are held, then in_ready drops.
- Simultaneous accept and drain in the same cycle: both happen, no bubble, no loss, no duplication.
- rst mid-operation: all in-flight beats discarded, no out_valid pulse in the cycle after reset.
- Arithmetic is unsigned modulo 2^WIDTH; flags are computed only from the beat's own sub bit.

Decomposition:
- Shared package cla_pkg:
  - constant LCU_W = 4;
  - typedef for the (p, g) 4-bit pair;
  - function computing group P/G.
- One natural sub-module: cla_lcu4 (4-bit p/g/c_in -> internal carries, c_out, group P, group G). Instantiated WIDTH/4 times across the two stages.
- Handshake control stays inline in cla_addsub_pipe.

Test Plan:
- Add overflow: a=0x7FFF, b=0x0001, sub=0 -> 2 cycles later result=0x8000, c_out=0, ovf=1, zero=0.
- Subtract borrow: a=0x0005, b=0x0007, sub=1 -> result=0xFFFE, c_out=0, ovf=0, zero=0.
- Carry wrap/zero, back-to-back: 0xFFFF+0x0001 then 0x8000-0x0001 on consecutive cycles.
  - Cycle N: result=0x0000, c_out=1, zero=1.
  - Cycle N+1: result=0x7FFF, c_out=1, ovf=1.
- Backpressure: hold out_ready=0 while streaming three beats.
  - Third beat sees in_ready=0.
  - First result holds stable.
  - After out_ready=1, results emerge in order, one per cycle, none dropped.
- Reset mid-flight: accept 0x1234+0x1111, assert rst next cycle -> out_valid stays 0, outputs 0; first post-reset beat 0x0001+0x0002 returns 0x0003 after 2 cycles.
